// File: rtl/core_scan_pkg.sv
// Shared types and constants for the core scan port: TAP states, IR opcodes,
// register widths and the operand latch layout.
package core_scan_pkg;

  localparam int IR_W     = 2;
  localparam int OPER_W   = 5;
  localparam int RES_W    = 4;
  localparam int DR_OP_W  = OPER_W + RES_W;
  localparam int IDCODE_W = 32;

  localparam logic [IR_W-1:0] IR_OPERATE = 2'b01;
  localparam logic [IR_W-1:0] IR_IDCODE  = 2'b10;
  localparam logic [IR_W-1:0] IR_BYPASS  = 2'b11;
  localparam logic [IR_W-1:0] IR_CAPTURE = 2'b01;

  typedef enum logic [3:0] {
    TAP_RESET,
    TAP_IDLE,
    TAP_SEL_DR,
    TAP_CAP_DR,
    TAP_SHIFT_DR,
    TAP_EXIT1_DR,
    TAP_PAUSE_DR,
    TAP_EXIT2_DR,
    TAP_UPD_DR,
    TAP_SEL_IR,
    TAP_CAP_IR,
    TAP_SHIFT_IR,
    TAP_EXIT1_IR,
    TAP_PAUSE_IR,
    TAP_EXIT2_IR,
    TAP_UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_OPERATE,
    SEL_IDCODE
  } dr_sel_e;

  // Operand latch layout: a in [1:0], b in [3:2], op in [4].
  typedef struct packed {
    logic       op;
    logic [1:0] b;
    logic [1:0] a;
  } oper_t;

endpackage

// File: rtl/core_scan_port_tap_fsm.sv
// IEEE 1149.1 TAP controller: state register and next-state logic only;
// all capture/shift/update decoding lives in core_scan_port.
module tap_fsm
  import core_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_e state
);

  tap_state_e state_next;

  // NOTE: asynchronous reset belongs in the sensitivity list; the TAP must
  // land in Test-Logic-Reset without needing a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= TAP_RESET;
    else     state <= state_next;
  end

  // NOTE: a default assignment ahead of the case keeps this block free of
  // inferred latches even if an arm is missed.
  always_comb begin
    state_next = state;
    unique case (state)
      TAP_RESET:    state_next = tms ? TAP_RESET    : TAP_IDLE;
      TAP_IDLE:     state_next = tms ? TAP_SEL_DR   : TAP_IDLE;
      TAP_SEL_DR:   state_next = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_CAP_DR:   state_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: state_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR: state_next = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
      TAP_PAUSE_DR: state_next = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR: state_next = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
      TAP_UPD_DR:   state_next = tms ? TAP_SEL_DR   : TAP_IDLE;
      TAP_SEL_IR:   state_next = tms ? TAP_RESET    : TAP_CAP_IR;
      TAP_CAP_IR:   state_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: state_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR: state_next = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
      TAP_PAUSE_IR: state_next = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR: state_next = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
      TAP_UPD_IR:   state_next = tms ? TAP_SEL_DR   : TAP_IDLE;
      default:      state_next = TAP_RESET;
    endcase
  end

endmodule

// File: rtl/core_scan_port.sv
// Scan port that loads operands into the core logic and reads its result back.
// Define CORE_SCAN_IDCODE_EN to include the IDCODE instruction and register.
module core_scan_port
  import core_scan_pkg::*;
#(
  parameter logic [IDCODE_W-1:0] IDCODE_VALUE = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tms,
  input  logic             tdi,
  output logic             tdo,
  output logic             tdo_en,
  output logic [1:0]       core_a,
  output logic [1:0]       core_b,
  output logic             core_op,
  input  logic [RES_W-1:0] core_result
);

`ifdef CORE_SCAN_IDCODE_EN
  localparam logic [IR_W-1:0] IR_RESET = IR_IDCODE;
`else
  localparam logic [IR_W-1:0] IR_RESET = IR_BYPASS;
`endif

  tap_state_e         state;
  logic [IR_W-1:0]    ir_sr;
  logic [IR_W-1:0]    ir;
  logic [DR_OP_W-1:0] op_sr;
  logic               bypass_bit;
  oper_t              latch;
  dr_sel_e            dr_sel;
  logic               capture_dr, shift_dr, update_dr;
  logic               capture_ir, shift_ir, update_ir;
  logic               dr_tdo;

  tap_fsm u_tap_fsm (
    .clk   (clk),
    .rst   (rst),
    .tms   (tms),
    .state (state)
  );

  // Output decode of the TAP state.
  always_comb begin
    capture_dr = (state == TAP_CAP_DR);
    shift_dr   = (state == TAP_SHIFT_DR);
    update_dr  = (state == TAP_UPD_DR);
    capture_ir = (state == TAP_CAP_IR);
    shift_ir   = (state == TAP_SHIFT_IR);
    update_ir  = (state == TAP_UPD_IR);
  end

  always_comb begin
    dr_sel = SEL_BYPASS;
    if (ir == IR_OPERATE) dr_sel = SEL_OPERATE;
`ifdef CORE_SCAN_IDCODE_EN
    else if (ir == IR_IDCODE) dr_sel = SEL_IDCODE;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_sr <= '0;
      ir    <= IR_RESET;
    end else begin
      if (capture_ir)    ir_sr <= IR_CAPTURE;
      else if (shift_ir) ir_sr <= {tdi, ir_sr[IR_W-1]};
      if (state == TAP_RESET) ir <= IR_RESET;
      else if (update_ir)     ir <= ir_sr;
    end
  end

  // Capture reads back the held operands alongside the core's current result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_sr <= '0;
    end else if (dr_sel == SEL_OPERATE) begin
      if (capture_dr)    op_sr <= {latch, core_result};
      else if (shift_dr) op_sr <= {tdi, op_sr[DR_OP_W-1:1]};
    end
  end

  // The latch survives Test-Logic-Reset; only rst or an OPERATE update touches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   latch <= '0;
    else if (update_dr && dr_sel == SEL_OPERATE) latch <= op_sr[DR_OP_W-1:RES_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bypass_bit <= 1'b0;
    end else if (dr_sel == SEL_BYPASS) begin
      if (capture_dr)    bypass_bit <= 1'b0;
      else if (shift_dr) bypass_bit <= tdi;
    end
  end

`ifdef CORE_SCAN_IDCODE_EN
  logic [IDCODE_W-1:0] idcode_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idcode_sr <= '0;
    end else if (dr_sel == SEL_IDCODE) begin
      if (capture_dr)    idcode_sr <= IDCODE_VALUE;
      else if (shift_dr) idcode_sr <= {tdi, idcode_sr[IDCODE_W-1:1]};
    end
  end

  always_comb begin
    unique case (dr_sel)
      SEL_OPERATE: dr_tdo = op_sr[0];
      SEL_IDCODE:  dr_tdo = idcode_sr[0];
      default:     dr_tdo = bypass_bit;
    endcase
  end
`else
  logic unused_idcode;
  assign unused_idcode = ^IDCODE_VALUE;

  always_comb begin
    dr_tdo = (dr_sel == SEL_OPERATE) ? op_sr[0] : bypass_bit;
  end
`endif

  always_comb begin
    tdo    = 1'b0;
    tdo_en = shift_ir | shift_dr;
    if (shift_ir)      tdo = ir_sr[0];
    else if (shift_dr) tdo = dr_tdo;
  end

  assign core_a  = latch.a;
  assign core_b  = latch.b;
  assign core_op = latch.op;

endmodule

// File: tb/tb_core_scan_port.sv
// Directed bench for core_scan_port with a combinational add/multiply core
// model; honours CORE_SCAN_IDCODE_EN when choosing the reset-time expectation.
module tb_core_scan_port;

  logic       clk = 1'b0;
  logic       rst;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic [1:0] core_a;
  logic [1:0] core_b;
  logic       core_op;
  logic [3:0] core_result;

  int checks   = 0;
  int failures = 0;

  core_scan_port dut (
    .clk         (clk),
    .rst         (rst),
    .tms         (tms),
    .tdi         (tdi),
    .tdo         (tdo),
    .tdo_en      (tdo_en),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_op     (core_op),
    .core_result (core_result)
  );

  always #5 clk = ~clk;

  // Core logic model: op=1 adds, op=0 multiplies.
  always_comb begin
    core_result = core_op ? ({2'b00, core_a} + {2'b00, core_b})
                          : ({2'b00, core_a} * {2'b00, core_b});
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge clk);
    #1;
  endtask

  // From Run-Test/Idle: IR scan, returning the captured IR bits.
  task automatic ir_scan(input logic [1:0] code, output logic [1:0] cap);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    cap[0] = tdo;
    tick(1'b0, code[0]);
    cap[1] = tdo;
    tick(1'b1, code[1]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // From Run-Test/Idle: DR scan of n bits LSB first, optional Pause-DR detour
  // after bit pause_at, ending with Update-DR and back in Run-Test/Idle.
  task automatic dr_scan(input int n, input logic [63:0] din, input int pause_at,
                         output logic [63:0] dout);
    dout = '0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      if (i == pause_at && i != n - 1) begin
        tick(1'b1, din[i]);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
      end else begin
        tick(i == n - 1, din[i]);
      end
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  logic [63:0] dout;
  logic [1:0]  icap;

  initial begin
    rst = 1'b1;
    tms = 1'b1;
    tdi = 1'b0;
    #12;
    check("rst_core_a", core_a, 0);
    check("rst_core_b", core_b, 0);
    check("rst_core_op", core_op, 0);
    check("rst_tdo_en", tdo_en, 0);
    rst = 1'b0;
    repeat (5) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("idle_tdo_en", tdo_en, 0);
    check("idle_tdo", tdo, 0);

    // Reset-selected DR: IDCODE with the macro, otherwise BYPASS.
    dr_scan(32, 64'hFFFF_FFFF, -1, dout);
`ifdef CORE_SCAN_IDCODE_EN
    check("reset_dr_idcode", dout[31:0], 32'h0000_0001);
`else
    check("reset_dr_bypass", dout[31:0], 32'hFFFF_FFFE);
`endif

    ir_scan(2'b01, icap);
    check("ir_capture", icap, 2'b01);
    dr_scan(9, 64'h0B0, -1, dout);
    check("op1_readback", dout[8:0], 9'h000);
    check("op1_core_a", core_a, 3);
    check("op1_core_b", core_b, 2);
    check("op1_core_op", core_op, 0);

    // Readback of {01011, 0110}; load op=1, A=3, B=3.
    dr_scan(9, 64'h1F0, -1, dout);
    check("op2_tdo_seq", dout[8:0], 9'h0B6);
    check("op2_core_a", core_a, 3);
    check("op2_core_b", core_b, 3);
    check("op2_core_op", core_op, 1);

    dr_scan(9, 64'h1F0, 3, dout);
    check("pause_result", dout[3:0], 4'b0110);
    check("pause_full", dout[8:0], 9'h1F6);
    check("pause_core_op", core_op, 1);

    ir_scan(2'b11, icap);
    check("ir_capture_byp", icap, 2'b01);
    dr_scan(8, 64'hB3, -1, dout);
    check("bypass_delay", dout[7:0], 8'h66);
    check("bypass_core_a", core_a, 3);
    check("bypass_core_b", core_b, 3);
    check("bypass_core_op", core_op, 1);

    // Abort a scan with rst after 4 of 9 bits.
    ir_scan(2'b01, icap);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("shift_tdo_en", tdo_en, 1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_core_a", core_a, 0);
    check("abort_core_b", core_b, 0);
    check("abort_core_op", core_op, 0);
    check("abort_tdo_en", tdo_en, 0);
    check("abort_tdo", tdo, 0);
    #10;
    rst = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    ir_scan(2'b01, icap);
    dr_scan(9, 64'h060, -1, dout);
    check("post_rst_readback", dout[8:0], 9'h000);
    check("post_rst_core_a", core_a, 2);
    check("post_rst_core_b", core_b, 1);
    check("post_rst_core_op", core_op, 0);

    // Capture-DR -> Exit1-DR -> Update-DR with no shift.
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("noshift_core_a", core_a, 2);
    check("noshift_core_b", core_b, 1);
    check("noshift_core_op", core_op, 0);
    dr_scan(9, 64'h060, -1, dout);
    check("noshift_readback", dout[8:0], 9'h062);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
